// File: rtl/game_ctrl_pkg.sv
// Shared widths, state encoding and drop-period helper for the game flow controller.
package game_ctrl_pkg;

    localparam int SCORE_W = 16;
    localparam int LEVEL_W = 4;
    localparam int FRAME_W = 6;

    localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
    localparam logic [1:0] ST_CLEAR_ENC = 2'b01;
    localparam logic [1:0] ST_PLAY_ENC  = 2'b10;
    localparam logic [1:0] ST_OVER_ENC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_CLEAR = ST_CLEAR_ENC,
        ST_PLAY  = ST_PLAY_ENC,
        ST_OVER  = ST_OVER_ENC
    } game_state_t;

    // Gravity gets two frames faster per level until it hits the floor.
    function automatic logic [FRAME_W-1:0] drop_period(input logic [LEVEL_W-1:0] lvl,
                                                       input int init_frames,
                                                       input int min_frames);
        int p;
        p = init_frames - 2 * int'(lvl);
        if (p < min_frames) p = min_frames;
        return FRAME_W'(p);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge press pulse for one button.
module btn_debounce #(
    parameter int DB_CYC = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic             btn_m;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            press <= 1'b0;
            if (btn_s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYC - 1)) begin
                cnt   <= '0;
                level <= btn_s;
                press <= btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/CLEAR/PLAY/OVER FSM, frame-aligned move/drop commands, score and level.
// Optional AUTO_REPEAT_EN adds held-button auto-repeat of moves.
module game_flow_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int CLK_HZ           = 50_000_000,
    parameter int DEBOUNCE_MS      = 10,
    parameter int DROP_FRAMES_INIT = 30,
    parameter int DROP_FRAMES_MIN  = 5,
    parameter int SPEEDUP_EVERY    = 8
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY     = 20,
    parameter int REPEAT_RATE      = 4
`endif
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               vsync,
    input  logic               land,
    input  logic               top_overflow,
    output logic               clear_field,
    output logic               spawn,
    output logic               move_left,
    output logic               move_right,
    output logic               drop_step,
    output logic               game_over,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level
);

    localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int SUB_W  = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

    game_state_t        st;
    logic               lvl_l, lvl_r, press_l, press_r;
    logic               vs_m, vs_s, vs_d, vs_e;
    logic               tick_pre, frame_tick;
    logic               pend_l, pend_r, rearm;
    logic               rpt_l, rpt_r;
    logic [SUB_W-1:0]   land_sub;
    logic [FRAME_W-1:0] frame_cnt, period;
    logic [FRAME_W:0]   frame_nxt;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_left (
        .clk(sys_clk), .rst_n(sys_rst_n), .btn(btn_left),  .level(lvl_l), .press(press_l)
    );
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_right (
        .clk(sys_clk), .rst_n(sys_rst_n), .btn(btn_right), .level(lvl_r), .press(press_r)
    );

    // Extra stage lets moves be registered one cycle ahead and land on the frame_tick cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {vs_m, vs_s, vs_d, vs_e} <= 4'b1111;
        end else begin
            {vs_m, vs_s, vs_d, vs_e} <= {vsync, vs_m, vs_s, vs_d};
        end
    end

    assign tick_pre   = vs_d & ~vs_s;
    assign frame_tick = vs_e & ~vs_d;
    assign period     = drop_period(level, DROP_FRAMES_INIT, DROP_FRAMES_MIN);
    assign frame_nxt  = {1'b0, frame_cnt} + 1'b1;
    assign state      = st;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_run, rpt_hit;

    assign rpt_run = (st == ST_PLAY) && (lvl_l ^ lvl_r) && !press_l && !press_r;
    assign rpt_hit = rpt_run && tick_pre && (rpt_cnt == RPT_W'(REPEAT_DELAY - 1));
    assign rpt_l   = rpt_hit & lvl_l;
    assign rpt_r   = rpt_hit & lvl_r;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     rpt_cnt <= '0;
        else if (!rpt_run)  rpt_cnt <= '0;
        else if (rpt_hit)   rpt_cnt <= RPT_W'(REPEAT_DELAY - REPEAT_RATE);
        else if (tick_pre)  rpt_cnt <= rpt_cnt + 1'b1;
    end
`else
    assign rpt_l = 1'b0;
    assign rpt_r = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st          <= ST_IDLE;
            clear_field <= 1'b0;
            spawn       <= 1'b0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;
            drop_step   <= 1'b0;
            game_over   <= 1'b0;
            score       <= '0;
            level       <= '0;
            land_sub    <= '0;
            frame_cnt   <= '0;
            pend_l      <= 1'b0;
            pend_r      <= 1'b0;
            rearm       <= 1'b0;
        end else begin
            clear_field <= 1'b0;
            spawn       <= 1'b0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;
            drop_step   <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    if (press_l || press_r) begin
                        st          <= ST_CLEAR;
                        clear_field <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    score     <= '0;
                    level     <= '0;
                    land_sub  <= '0;
                    frame_cnt <= '0;
                    pend_l    <= 1'b0;
                    pend_r    <= 1'b0;
                    spawn     <= 1'b1;
                    st        <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (land) begin
                        // Landing cancels whatever this cycle would have scheduled.
                        pend_l    <= 1'b0;
                        pend_r    <= 1'b0;
                        frame_cnt <= '0;
                        if (top_overflow) begin
                            st        <= ST_OVER;
                            game_over <= 1'b1;
                            rearm     <= 1'b0;
                        end else begin
                            spawn <= 1'b1;
                            if (score != '1) begin
                                score <= score + 1'b1;
                                if (land_sub == SUB_W'(SPEEDUP_EVERY - 1)) begin
                                    land_sub <= '0;
                                    if (level != '1) level <= level + 1'b1;
                                end else begin
                                    land_sub <= land_sub + 1'b1;
                                end
                            end
                        end
                    end else begin
                        if (tick_pre && !(pend_l && pend_r)) begin
                            move_left  <= pend_l;
                            move_right <= pend_r;
                        end
                        pend_l <= (pend_l & ~tick_pre) | press_l | rpt_l;
                        pend_r <= (pend_r & ~tick_pre) | press_r | rpt_r;
                        if (frame_tick) begin
                            if (frame_nxt >= {1'b0, period}) begin
                                drop_step <= 1'b1;
                                frame_cnt <= '0;
                            end else begin
                                frame_cnt <= frame_nxt[FRAME_W-1:0];
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (frame_tick && !lvl_l && !lvl_r) rearm <= 1'b1;
                    if ((press_l || press_r) && rearm) begin
                        st          <= ST_CLEAR;
                        clear_field <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
